// File: rtl/sort_n_floats_using_fsm.sv
// rtl/sort_n_floats_using_fsm.sv - N-element float bubble sorter, one external compare per clock
// Optional feature macro: SORT_FLOATS_EARLY_EXIT_EN (finish after a pass with no swaps).
module sort_n_floats_using_fsm #(
  parameter int N    = 4,
  parameter int FLEN = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic [0:N-1][FLEN-1:0] unsorted,
  output logic                   valid_out,
  output logic [0:N-1][FLEN-1:0] sorted,
  output logic                   err,
  output logic                   busy,
  output logic [FLEN-1:0]        f_le_a,
  output logic [FLEN-1:0]        f_le_b,
  input  logic                   f_le_res,
  input  logic                   f_le_err
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 2);

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [0:N-1][FLEN-1:0] work_q, work_d;
  logic [CW-1:0]          j_q, j_d, pass_q, pass_d, jp1;
  logic                   err_flag_q, err_flag_d;
  logic                   swap, early;
`ifdef SORT_FLOATS_EARLY_EXIT_EN
  logic                   seen_q, seen_d;
`endif

  assign jp1 = j_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      work_q     <= '0;
      sorted     <= '0;
      j_q        <= '0;
      pass_q     <= '0;
      err_flag_q <= 1'b0;
`ifdef SORT_FLOATS_EARLY_EXIT_EN
      seen_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      j_q        <= j_d;
      pass_q     <= pass_d;
      err_flag_q <= err_flag_d;
`ifdef SORT_FLOATS_EARLY_EXIT_EN
      seen_q     <= seen_d;
`endif
      // Capture on entry to DONE so sorted is valid in the same cycle as valid_out
      if (state_q == COMPARE && state_d == DONE)
        sorted <= work_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    j_d        = j_q;
    pass_d     = pass_q;
    err_flag_d = err_flag_q;
    swap       = 1'b0;
    early      = 1'b0;
    f_le_a     = '0;
    f_le_b     = '0;
    valid_out  = 1'b0;
    err        = 1'b0;
    busy       = (state_q != IDLE);
`ifdef SORT_FLOATS_EARLY_EXIT_EN
    seen_d     = seen_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          work_d     = unsorted;
          j_d        = '0;
          pass_d     = '0;
          err_flag_d = 1'b0;
`ifdef SORT_FLOATS_EARLY_EXIT_EN
          seen_d     = 1'b0;
`endif
          state_d    = COMPARE;
        end
      end
      COMPARE: begin
        f_le_a = work_q[j_q];
        f_le_b = work_q[jp1];
        if (f_le_err) begin
          err_flag_d = 1'b1;
          state_d    = DONE;
        end else begin
          // Strict greater-than swaps only, keeping equal elements in input order
          swap = !f_le_res;
          if (swap) begin
            work_d[j_q] = work_q[jp1];
            work_d[jp1] = work_q[j_q];
          end
`ifdef SORT_FLOATS_EARLY_EXIT_EN
          early  = !(seen_q || swap);
          seen_d = seen_q || swap;
`endif
          if (j_q == LAST - pass_q) begin
            j_d    = '0;
            pass_d = pass_q + 1'b1;
`ifdef SORT_FLOATS_EARLY_EXIT_EN
            seen_d = 1'b0;
`endif
            if (pass_q == LAST || early)
              state_d = DONE;
          end else begin
            j_d = jp1;
          end
        end
      end
      DONE: begin
        valid_out = 1'b1;
        err       = err_flag_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sort_n_floats_using_fsm.sv
// tb/tb_sort_n_floats_using_fsm.sv - self-checking bench for sort_n_floats_using_fsm (N=4, 3, 2)
module tb_sort_n_floats_using_fsm;

  localparam logic [63:0] P1   = 64'h3FF0000000000000;
  localparam logic [63:0] P2   = 64'h4000000000000000;
  localparam logic [63:0] P3   = 64'h4008000000000000;
  localparam logic [63:0] M1   = 64'hBFF0000000000000;
  localparam logic [63:0] HALF = 64'h3FE0000000000000;
  localparam logic [63:0] M25  = 64'hC004000000000000;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  logic clk, rst;
  int   n_chk, n_err;

  logic              valid_in4, vo4, err4, busy4, res4, ferr4;
  logic [0:3][63:0]  unsorted4, sorted4;
  logic [63:0]       a4, b4;
  logic              valid_in3, vo3, err3, busy3, res3, ferr3;
  logic [0:2][63:0]  unsorted3, sorted3;
  logic [63:0]       a3, b3;
  logic              valid_in2, vo2, err2, busy2, res2, ferr2;
  logic [0:1][63:0]  unsorted2, sorted2;
  logic [63:0]       a2, b2;

  sort_n_floats_using_fsm #(.N(4), .FLEN(64)) dut4 (
    .clk(clk), .rst(rst), .valid_in(valid_in4), .unsorted(unsorted4),
    .valid_out(vo4), .sorted(sorted4), .err(err4), .busy(busy4),
    .f_le_a(a4), .f_le_b(b4), .f_le_res(res4), .f_le_err(ferr4));
  sort_n_floats_using_fsm #(.N(3), .FLEN(64)) dut3 (
    .clk(clk), .rst(rst), .valid_in(valid_in3), .unsorted(unsorted3),
    .valid_out(vo3), .sorted(sorted3), .err(err3), .busy(busy3),
    .f_le_a(a3), .f_le_b(b3), .f_le_res(res3), .f_le_err(ferr3));
  sort_n_floats_using_fsm #(.N(2), .FLEN(64)) dut2 (
    .clk(clk), .rst(rst), .valid_in(valid_in2), .unsorted(unsorted2),
    .valid_out(vo2), .sorted(sorted2), .err(err2), .busy(busy2),
    .f_le_a(a2), .f_le_b(b2), .f_le_res(res2), .f_le_err(ferr2));

  function automatic logic is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  function automatic logic fle(input logic [63:0] x, input logic [63:0] y);
    return $bitstoreal(x) <= $bitstoreal(y);
  endfunction

  // Comparator model for each instance
  assign res4  = fle(a4, b4);
  assign ferr4 = is_nan(a4) || is_nan(b4);
  assign res3  = fle(a3, b3);
  assign ferr3 = is_nan(a3) || is_nan(b3);
  assign res2  = fle(a2, b2);
  assign ferr2 = is_nan(a2) || is_nan(b2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stable ascending sort of the input values
  function automatic logic [0:3][63:0] ref_sort(input logic [0:3][63:0] v);
    logic [63:0] q[$];
    logic [0:3][63:0] r;
    for (int i = 0; i < 4; i++) begin
      int k = q.size();
      while (k > 0 && $bitstoreal(q[k-1]) > $bitstoreal(v[i])) k--;
      q.insert(k, v[i]);
    end
    for (int i = 0; i < 4; i++) r[i] = q[i];
    return r;
  endfunction

  // Bubble passes needed = largest count of greater elements to an element's left
  function automatic int exp_lat(input logic [0:3][63:0] v);
    int p = 0;
    int passes;
    int comps = 0;
    for (int i = 0; i < 4; i++) begin
      int c = 0;
      for (int k = 0; k < i; k++)
        if ($bitstoreal(v[k]) > $bitstoreal(v[i])) c++;
      if (c > p) p = c;
    end
`ifdef SORT_FLOATS_EARLY_EXIT_EN
    passes = (p + 1 < 3) ? p + 1 : 3;
`else
    passes = 3;
`endif
    for (int q = 0; q < passes; q++) comps += 3 - q;
    return comps + 1;
  endfunction

  // Called #1 after an edge; drives one request and observes cycles 1..12
  task automatic run4(input logic [0:3][63:0] v, input int inj, output int lat,
                      output int pulses, output int busy_n, output logic e,
                      output logic [0:3][63:0] s, output logic stray);
    valid_in4 = 1'b1;
    unsorted4 = v;
    @(posedge clk); #1;
    valid_in4 = 1'b0;
    lat = -1; pulses = 0; busy_n = 0; e = 1'b0; s = '0; stray = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == inj) begin
        valid_in4 = 1'b1;
        unsorted4 = {P1, P1, P1, P1};
      end else begin
        valid_in4 = 1'b0;
      end
      if (busy4) busy_n++;
      if (err4 && !vo4) stray = 1'b1;
      if (vo4) begin
        pulses++;
        if (lat < 0) begin
          lat = c; e = err4; s = sorted4;
        end
      end
      @(posedge clk); #1;
    end
    valid_in4 = 1'b0;
  endtask

  initial begin
    int lat, pulses, busy_n, exp_l;
    logic e, stray;
    logic [0:3][63:0] s, v;
    logic [0:2][63:0] s3;
    logic [0:1][63:0] s2;
    logic [63:0] pool [6];
    pool = '{P1, P2, P3, M1, HALF, M25};
    n_chk = 0; n_err = 0;
    rst = 1'b1;
    valid_in4 = 1'b0; valid_in3 = 1'b0; valid_in2 = 1'b0;
    unsorted4 = '0; unsorted3 = '0; unsorted2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_busy", 256'(busy4), 256'(0));
    check("rst_valid_out", 256'(vo4), 256'(0));
    check("rst_err", 256'(err4), 256'(0));
    check("rst_sorted", 256'(sorted4), 256'(0));
    check("rst_f_le_a", 256'(a4), 256'(0));

    // Unsorted mix
    run4({P3, P1, M1, P2}, 0, lat, pulses, busy_n, e, s, stray);
    check("t1_latency", 256'(lat), 256'(7));
    check("t1_pulses", 256'(pulses), 256'(1));
    check("t1_busy_cycles", 256'(busy_n), 256'(7));
    check("t1_err", 256'(e), 256'(0));
    check("t1_sorted", 256'(s), 256'({M1, P1, P2, P3}));
    check("t1_err_qualified", 256'(stray), 256'(0));
    check("t1_idle_f_le_b", 256'(b4), 256'(0));

    // Already sorted
    run4({M1, P1, P2, P3}, 0, lat, pulses, busy_n, e, s, stray);
`ifdef SORT_FLOATS_EARLY_EXIT_EN
    check("t2_latency", 256'(lat), 256'(4));
`else
    check("t2_latency", 256'(lat), 256'(7));
`endif
    check("t2_sorted", 256'(s), 256'({M1, P1, P2, P3}));

    // NaN abort on first comparison
    run4({P2, QNAN, P1, P3}, 0, lat, pulses, busy_n, e, s, stray);
    check("t3_latency", 256'(lat), 256'(2));
    check("t3_err", 256'(e), 256'(1));
    check("t3_sorted", 256'(s), 256'({P2, QNAN, P1, P3}));
    check("t3_busy_cycles", 256'(busy_n), 256'(2));
    check("t3_pulses", 256'(pulses), 256'(1));

    // Reversed, second request while busy
    run4({P3, P2, P1, M1}, 3, lat, pulses, busy_n, e, s, stray);
    check("t4_pulses", 256'(pulses), 256'(1));
    check("t4_latency", 256'(lat), 256'(7));
    check("t4_sorted", 256'(s), 256'({M1, P1, P2, P3}));

    // Reset mid-sort in cycle 3
    valid_in4 = 1'b1;
    unsorted4 = {P3, P2, P1, M1};
    @(posedge clk); #1 valid_in4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("t5_busy", 256'(busy4), 256'(0));
    check("t5_valid_out", 256'(vo4), 256'(0));
    check("t5_sorted", 256'(sorted4), 256'(0));
    run4({P2, M1, P3, P1}, 0, lat, pulses, busy_n, e, s, stray);
    check("t5_after_latency", 256'(lat), 256'(7));
    check("t5_after_sorted", 256'(s), 256'({M1, P1, P2, P3}));

    // N=2 with equal values
    valid_in2 = 1'b1;
    unsorted2 = {P1, P1};
    @(posedge clk); #1 valid_in2 = 1'b0;
    lat = -1; s2 = '0;
    for (int c = 1; c <= 10; c++) begin
      if (vo2 && lat < 0) begin lat = c; s2 = sorted2; end
      @(posedge clk); #1;
    end
    check("n2_latency", 256'(lat), 256'(2));
    check("n2_sorted", 256'(s2), 256'({P1, P1}));

    // N=3
    valid_in3 = 1'b1;
    unsorted3 = {P2, P3, P1};
    @(posedge clk); #1 valid_in3 = 1'b0;
    lat = -1; s3 = '0;
    for (int c = 1; c <= 10; c++) begin
      if (vo3 && lat < 0) begin lat = c; s3 = sorted3; end
      @(posedge clk); #1;
    end
    check("n3_latency", 256'(lat), 256'(4));
    check("n3_sorted", 256'(s3), 256'({P1, P2, P3}));

    // Random vectors from a small pool (duplicates likely)
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 4; i++) v[i] = pool[$urandom_range(0, 5)];
      exp_l = exp_lat(v);
      run4(v, 0, lat, pulses, busy_n, e, s, stray);
      check($sformatf("rnd%0d_latency", t), 256'(lat), 256'(exp_l));
      check($sformatf("rnd%0d_sorted", t), 256'(s), 256'(ref_sort(v)));
      check($sformatf("rnd%0d_err", t), 256'({e, stray}), 256'(0));
      check($sformatf("rnd%0d_pulses", t), 256'(pulses), 256'(1));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
